aes_spi_frontend: RTL
=====================

# aes_spi_frontend

Synchronous SPI slave front-end for the AES encrypt/decrypt cores. It deserialises key frames and message frames arriving from the SPI main controller on `sdi`, and issues one-cycle load pulses to the AES core. It captures the core's 128-bit result and serialises it back on `sdo` during a readout frame. One instance sits inside each of the encrypt and decrypt wrappers, between the shared SPI bus and the cipher datapath.

## Interface
- `KEY_FRAME_BITS`, 258: key frame length; 2-bit key-size code plus a 256-bit key field.
- `MSG_FRAME_BITS`, 128: message and readout frame length.
- `clk  in  1`: system clock; the SPI bit clock equals `clk`.
- `rst  in  1`: asynchronous, active-high reset.
- `cs  in  1`: chip select, active low.
- `sdi  in  1`: serial data in, MSB first.
- `sdo  out  1`: serial data out, MSB first; 0 whenever `cs`=1.
- `key_size  out  2`: key-size code; 00=128, 01=192, 10=256, 11 reserved.
- `key  out  256`: key, right-aligned (a 128-bit key occupies bits [127:0]).
- `key_load  out  1`: one-cycle pulse; `key`/`key_size` valid.
- `msg  out  128`: message block.
- `msg_start  out  1`: one-cycle pulse; start the core on `msg`.
- `result  in  128`: core output.
- `result_valid  in  1`: one-cycle pulse from the core.
- `busy  out  1`: high in state BUSY.

## Operation
- **Bit counter `cnt`** (9 bits)
  - Cleared while `cs`=1.
  - Increments on each `clk` with `cs`=0.
  - Saturates at 511.
- **Input shift register** (258 bits)
  - On each `clk` with `cs`=0: `rx <= {rx[256:0], sdi}`.
- **End of frame**
  - A frame ends on the first `clk` where `cs`=1 and the previous `cs`=0 (rising `cs` detected on a registered copy).
  - The frame is classified by `cnt` at that edge.
- **States:** NOKEY, KEYED, BUSY, READY.
  - 258-bit frame in NOKEY, KEYED or READY:
    - `key_size <= rx[257:256]`, `key <= rx[255:0]`, pulse `key_load`.
    - Next state KEYED; any held result is discarded.
    - Code 11 is discarded with no pulse and no state change.
  - 128-bit frame in KEYED: `msg <= rx[127:0]`, pulse `msg_start`, go to BUSY.
  - 128-bit frame in NOKEY: discarded.
  - BUSY: every frame is ignored. On `result_valid`, load the output shift register with `result` and go to READY.
  - READY: while `cs`=0, `sdo` = output shift register bit 127, and the register shifts left one bit per `clk`.
    - A frame of ≥128 bits: go to KEYED; its `sdi` content is ignored.
    - A frame of <128 bits: reload the register from the held result and stay in READY.
  - Any other frame length: discarded, no state change.
- `result_valid` outside BUSY is ignored.

## Timing
- **Reset values:**
  - state NOKEY; `cnt`=0; all registers 0.
  - `sdo`=0, `key_load`=0, `msg_start`=0, `busy`=0, `key`=0, `key_size`=0, `msg`=0.
- **Load latency:** `key_load`/`msg_start` assert exactly 2 cycles after the last data bit is sampled; the `cs` edge register accounts for the first cycle.
- **Busy timing:** `busy` rises in the same cycle as `msg_start` and falls in the cycle after `result_valid`.
- **Readout:**
  - The first result bit (bit 127) is on `sdo` in the first cycle `cs`=0 in READY.
  - `sdo` is combinational: `cs` gated with the register MSB.
  - 128 bits take 128 cycles.
- **Reset mid-frame:** immediate return to the reset state; the partial frame is lost.
- **Abort:** `cs` rising early is an ordinary short frame and is discarded.
- **Simultaneous events:** a frame end coinciding with `result_valid` in BUSY is ignored; `result_valid` is taken.
- **Overlong frames:** bits beyond the frame length shift through `rx`; only the last 258/128 bits count. Classification uses exact `cnt`, except readout, which uses ≥128.

## Structure
- **Package `aes_spi_pkg`:**
  - Frame-length constants.
  - Key-size codes `KS_128`/`KS_192`/`KS_256`/`KS_RSVD`.
  - State enum `NOKEY`/`KEYED`/`BUSY`/`READY`.
- **Sub-module `spi_frame_rx`:** `cs` edge register, `cnt`, input shift register, and a `frame_end` pulse with `frame_len`.
- **Top level:** FSM, output registers and `sdo` serialiser.

## Test plan
- Key frame {00, 256'h000102030405060708090a0b0c0d0e0f} -> `key_load` 2 cycles after the last bit; `key_size`=00; `key[127:0]`=000102…0f.
- Message 00112233445566778899aabbccddeeff, then `result_valid` with 69c4e0d86a7b0430d8cdb78070b4c55a -> `msg_start` pulse; `busy` high until the cycle after `result_valid`; a 128-cycle readout returns 69c4…c55a MSB-first; state returns to KEYED.
- Readout with `cs` low during BUSY (core delays 70 cycles) -> `sdo`=0 throughout; state stays BUSY; no pulses.
- 100-bit aborted frame in KEYED, then a valid message -> no pulse for the first frame; `msg_start` for the second only.
- Key frame with code 11 in NOKEY -> no `key_load`; a following message frame is discarded.
- `rst` asserted at bit 60 of a key frame -> all outputs 0 immediately; state NOKEY; the next full key frame loads normally.

Source files
------------

// File: rtl/aes_spi_pkg.sv
// Shared constants and types for the AES SPI slave front-end.
// Frame lengths, key-size codes and the front-end state encoding.
package aes_spi_pkg;

    localparam int KEY_FRAME_BITS = 258;
    localparam int MSG_FRAME_BITS = 128;
    localparam int CNT_W          = 9;

    localparam logic [CNT_W-1:0] KEY_LEN = CNT_W'(KEY_FRAME_BITS);
    localparam logic [CNT_W-1:0] MSG_LEN = CNT_W'(MSG_FRAME_BITS);

    typedef enum logic [1:0] {
        KS_128  = 2'b00,
        KS_192  = 2'b01,
        KS_256  = 2'b10,
        KS_RSVD = 2'b11
    } key_size_e;

    typedef enum logic [1:0] {
        NOKEY,
        KEYED,
        BUSY,
        READY
    } state_e;

endpackage

// File: rtl/aes_spi_frontend_frame_rx.sv
// SPI frame receiver: bit counter, input shift register and a
// registered end-of-frame pulse carrying the frame length.
module spi_frame_rx
    import aes_spi_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cs,
    input  logic                      sdi,
    output logic [KEY_FRAME_BITS-1:0] rx,
    output logic                      frame_end,
    output logic [CNT_W-1:0]          frame_len
);

    logic             cs_q;
    logic [CNT_W-1:0] cnt;

    // frame_end/frame_len are registered so the FSM sees the length
    // after cnt has already been cleared by the high cs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cs_q      <= 1'b0;
            cnt       <= '0;
            rx        <= '0;
            frame_end <= 1'b0;
            frame_len <= '0;
        end else begin
            cs_q      <= cs;
            frame_end <= cs & ~cs_q;
            frame_len <= cnt;
            if (cs) begin
                cnt <= '0;
            end else begin
                rx <= {rx[KEY_FRAME_BITS-2:0], sdi};
                if (cnt != '1)
                    cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/aes_spi_frontend.sv
// SPI slave front-end for the AES cores: key/message frame decode,
// load pulses, and MSB-first serialisation of the cipher result.
module aes_spi_frontend
    import aes_spi_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         cs,
    input  logic         sdi,
    output logic         sdo,
    output logic [1:0]   key_size,
    output logic [255:0] key,
    output logic         key_load,
    output logic [127:0] msg,
    output logic         msg_start,
    input  logic [127:0] result,
    input  logic         result_valid,
    output logic         busy
);

    logic [KEY_FRAME_BITS-1:0] rx;
    logic                      frame_end;
    logic [CNT_W-1:0]          frame_len;
    state_e                    state;
    logic [MSG_FRAME_BITS-1:0] osr;
    logic [MSG_FRAME_BITS-1:0] held;

    spi_frame_rx u_rx (
        .clk       (clk),
        .rst       (rst),
        .cs        (cs),
        .sdi       (sdi),
        .rx        (rx),
        .frame_end (frame_end),
        .frame_len (frame_len)
    );

    assign sdo = ~cs & (state == READY) & osr[MSG_FRAME_BITS-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= NOKEY;
            key_size  <= '0;
            key       <= '0;
            key_load  <= 1'b0;
            msg       <= '0;
            msg_start <= 1'b0;
            busy      <= 1'b0;
            osr       <= '0;
            held      <= '0;
        end else begin
            key_load  <= 1'b0;
            msg_start <= 1'b0;
            if (state == READY && !cs)
                osr <= {osr[MSG_FRAME_BITS-2:0], 1'b0};
            case (state)
                BUSY: begin
                    if (result_valid) begin
                        osr   <= result;
                        held  <= result;
                        busy  <= 1'b0;
                        state <= READY;
                    end
                end
                default: begin
                    if (frame_end) begin
                        if (frame_len == KEY_LEN) begin
                            // Reserved key-size code leaves everything as is.
                            if (rx[257:256] != KS_RSVD) begin
                                key_size <= rx[257:256];
                                key      <= rx[255:0];
                                key_load <= 1'b1;
                                held     <= '0;
                                osr      <= '0;
                                state    <= KEYED;
                            end
                        end else if (state == KEYED && frame_len == MSG_LEN) begin
                            msg       <= rx[127:0];
                            msg_start <= 1'b1;
                            busy      <= 1'b1;
                            state     <= BUSY;
                        end else if (state == READY) begin
                            if (frame_len >= MSG_LEN)
                                state <= KEYED;
                            else
                                osr <= held;
                        end
                    end
                end
            endcase
        end
    end

endmodule
